// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, canonical NOP and the
// {pc, instr} entry that travels from fetch into the IF/ID register.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for both the fetch address queue and the response
// buffer; pop is evaluated before push so a full FIFO can push and pop together.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_id_fetch.sv
// Fetch stage: issues in-order imem requests from pc_in, drops wrong-path
// responses after a flush, buffers the rest and drives the IF/ID register.
module if_id_fetch
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            id_stall,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW+1:0] DEPTH_OCC = (CW + 2)'(DEPTH);

    logic [CW-1:0]   kill_cnt;
    logic [CW-1:0]   kill_next;
    logic [CW-1:0]   addr_count;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     in_flight;
    logic [CW:0]     flush_kill;
    logic [CW+1:0]   occ;
    logic            accept;
    logic            rsp_kill;
    logic            rsp_take;
    logic            flush_drop;
    logic            load_en;
    logic            bypass;
    logic            buf_push;
    logic            buf_pop;
    logic            addr_full;
    logic            addr_empty;
    logic            buf_full;
    logic            buf_empty;
    logic [XLEN-1:0] addr_head;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_entry;

    // Killed requests still occupy a slot until their response drains.
    assign in_flight = {1'b0, kill_cnt} + {1'b0, addr_count};
    assign occ       = {1'b0, in_flight} + {2'b00, buf_count};

    assign imem_req_valid = !reset && !flush && (occ < DEPTH_OCC);
    assign imem_req_addr  = pc_in;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_stall       = !accept;

    assign rsp_kill   = imem_rsp_valid && (kill_cnt != '0);
    assign rsp_take   = imem_rsp_valid && (kill_cnt == '0) && !addr_empty && !flush;
    assign flush_drop = imem_rsp_valid && (in_flight != '0);
    assign flush_kill = in_flight - (CW + 1)'(flush_drop);
    assign load_en    = !id_stall || !id_valid;
    assign bypass     = load_en && buf_empty && rsp_take;
    assign buf_push   = rsp_take && !bypass;
    assign buf_pop    = load_en && !buf_empty && !flush;
    assign buf_entry  = '{pc: addr_head, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) addr_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (accept),
        .push_data (pc_in),
        .pop       (rsp_take),
        .head      (addr_head),
        .full      (addr_full),
        .empty     (addr_empty),
        .count     (addr_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) rsp_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (buf_push),
        .push_data (buf_entry),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // On flush every live request becomes a kill, minus the one answered now.
    always_comb begin
        kill_next = kill_cnt;
        if (flush) begin
            kill_next = flush_kill[CW-1:0];
        end else if (rsp_kill) begin
            kill_next = kill_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_cnt <= '0;
        end else begin
            kill_cnt <= kill_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (load_en) begin
            if (!buf_empty) begin
                id_valid <= 1'b1;
                id_pc    <= buf_head.pc;
                id_instr <= buf_head.instr;
            end else if (rsp_take) begin
                id_valid <= 1'b1;
                id_pc    <= addr_head;
                id_instr <= imem_rsp_data;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

    assign id_pc_plus4 = id_pc + XLEN'(4);

    no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (in_flight != '0));
    occ_bounded: assert property (@(posedge clk) disable iff (reset)
        occ <= DEPTH_OCC);
    addr_no_overflow: assert property (@(posedge clk) disable iff (reset)
        accept |-> !addr_full);
    buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        buf_push |-> (!buf_full || buf_pop));

endmodule
